// File: rtl/atm_sample_pkg.sv
// Shared constants for the sample pointer unit: the default widths of the
// ROM address, the ROM sample and the sample-period counter.
package atm_sample_pkg;

    localparam int DEF_ADDR_W   = 8;
    localparam int DEF_DATA_W   = 8;
    localparam int DEF_PERIOD_W = 16;

endpackage : atm_sample_pkg

// File: rtl/sample_period_timer.sv
// Sample-period timer. It counts 0..period-1 while enabled and pulses
// 'expired' for the one cycle in which the count sits at period-1, then
// restarts at 0. A period of 0 behaves like a period of 1. When disabled,
// the count is held at 0 and 'expired' stays low. 'clear' restarts the count.
module sample_period_timer
    import atm_sample_pkg::*;
#(
    parameter int PERIOD_W = DEF_PERIOD_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                clear,
    input  logic [PERIOD_W-1:0] period,
    output logic                expired
);

    localparam logic [PERIOD_W-1:0] ONE = PERIOD_W'(1);

    logic [PERIOD_W-1:0] count_q;
    logic [PERIOD_W-1:0] count_d;
    logic [PERIOD_W-1:0] last_count;

    // Terminal count and next count. '>=' lets a count that is already past
    // a freshly lowered period wrap immediately.
    always_comb begin
        last_count = (period == '0) ? '0 : (period - ONE);
        expired    = enable && (count_q >= last_count);
        count_d    = count_q;
        if (clear || !enable) begin
            count_d = '0;
        end else if (expired) begin
            count_d = '0;
        end else begin
            count_d = count_q + ONE;
        end
    end

    // Count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule : sample_period_timer

// File: rtl/sample_pointer_unit.sv
// Sample pointer unit: walks a ROM address pointer from a latched start
// address towards a latched end address, flags the end match, times the
// sample period and holds the captured sample for a valid/ready consumer.
//
// Handshake: sample_out is transferred on every rising edge where
// sample_valid && sample_ready. A capture always loads the newest ROM data,
// and the latest sample wins over one that has not yet been taken.
//
// Optional feature: define SAMPLE_OVERRUN_DET_EN to add a sticky 'overrun'
// output. It is set when a capture overwrites a sample that is still
// waiting, and it is cleared by load_ptrs or rst.
module sample_pointer_unit
    import atm_sample_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int PERIOD_W = DEF_PERIOD_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_ptrs,
    input  logic                increment,
    input  logic                sample_capture,
    input  logic [ADDR_W-1:0]   start_addr,
    input  logic [ADDR_W-1:0]   end_addr,
    input  logic [PERIOD_W-1:0] period_cycles,
    input  logic [DATA_W-1:0]   rom_data,
    output logic [ADDR_W-1:0]   rom_addr,
    output logic                val_match,
    output logic                period_expired,
    output logic [DATA_W-1:0]   sample_out,
    output logic                sample_valid,
`ifdef SAMPLE_OVERRUN_DET_EN
    output logic                overrun,
`endif
    input  logic                sample_ready
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    logic [ADDR_W-1:0] ptr_q,    ptr_d;
    logic [ADDR_W-1:0] end_q,    end_d;
    logic              active_q, active_d;
    logic [DATA_W-1:0] sample_q, sample_d;
    logic              valid_q,  valid_d;

    // End-of-sequence match, decoded from registers only
    always_comb begin
        val_match = active_q && (ptr_q == end_q);
    end

    // Pointer and active flag: load wins over increment. The pointer keeps
    // advancing past the end address; only the active flag drops there.
    always_comb begin
        ptr_d    = ptr_q;
        end_d    = end_q;
        active_d = active_q;
        if (load_ptrs) begin
            ptr_d    = start_addr;
            end_d    = end_addr;
            active_d = 1'b1;
        end else if (increment) begin
            ptr_d = ptr_q + ADDR_ONE;
            if (val_match) begin
                active_d = 1'b0;
            end
        end
    end

    // Sample holding register with valid/ready handshake
    always_comb begin
        sample_d = sample_q;
        valid_d  = valid_q;
        if (sample_capture) begin
            sample_d = rom_data;
            valid_d  = 1'b1;
        end else if (valid_q && sample_ready) begin
            valid_d = 1'b0;
        end
    end

    // Pointer, match and capture state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q    <= '0;
            end_q    <= '0;
            active_q <= 1'b0;
            sample_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            ptr_q    <= ptr_d;
            end_q    <= end_d;
            active_q <= active_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
        end
    end

`ifdef SAMPLE_OVERRUN_DET_EN
    logic overrun_q, overrun_d;

    // Sticky overrun: a capture lands on a sample nobody has taken yet
    always_comb begin
        overrun_d = overrun_q;
        if (load_ptrs) begin
            overrun_d = 1'b0;
        end else if (sample_capture && valid_q && !sample_ready) begin
            overrun_d = 1'b1;
        end
    end

    // Overrun flag register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign overrun = overrun_q;
`endif

    // Period timer runs only while a sequence is active; load restarts it
    sample_period_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .enable  (active_q),
        .clear   (load_ptrs),
        .period  (period_cycles),
        .expired (period_expired)
    );

    assign rom_addr     = ptr_q;
    assign sample_out   = sample_q;
    assign sample_valid = valid_q;

endmodule : sample_pointer_unit
